// File: rtl/display_scan_controller.sv
// Time-multiplexed 4-digit hex display scanner; each digit is driven for STROBE_PERIOD cycles.
// All outputs registered (1-cycle latency); new data is double-buffered and only swapped in at frame boundaries.
module display_scan_controller #(
    parameter int STROBE_PERIOD = 100000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ENABLE,
    input  logic        LOAD,
    input  logic [15:0] DIGITS_IN,
    input  logic [3:0]  DOTS_IN,
    output logic [1:0]  SEGMENT,
    output logic [3:0]  BINARY_OUT,
    output logic        DOT_OUT,
    output logic        BLANK,
    output logic        UPDATED
);

    localparam int CW = (STROBE_PERIOD > 2) ? $clog2(STROBE_PERIOD) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STROBE_PERIOD - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   act_dig_q, act_dig_d;
    logic [3:0]    act_dot_q, act_dot_d;
    logic [15:0]   pend_dig_q, pend_dig_d;
    logic [3:0]    pend_dot_q, pend_dot_d;
    logic          pend_vld_q, pend_vld_d;
    logic [1:0]    seg_q, seg_d;
    logic [3:0]    bin_q, bin_d;
    logic          dot_q, dot_d;
    logic          blank_q, blank_d;
    logic          upd_q, upd_d;
    logic          wrap;
    logic          boundary;

    always_comb begin
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        act_dig_d  = act_dig_q;
        act_dot_d  = act_dot_q;
        pend_dig_d = pend_dig_q;
        pend_dot_d = pend_dot_q;
        pend_vld_d = pend_vld_q;
        blank_d    = blank_q;
        upd_d      = 1'b0;
        wrap       = (cnt_q == CNT_MAX);
        boundary   = wrap && (idx_q == 2'd3);

        if (!ENABLE) begin
            // Blanked: scan parked at digit 0, loads go straight to the active buffer.
            cnt_d   = '0;
            idx_d   = 2'd0;
            blank_d = 1'b1;
            if (LOAD) begin
                act_dig_d  = DIGITS_IN;
                act_dot_d  = DOTS_IN;
                pend_vld_d = 1'b0;
                upd_d      = 1'b1;
            end
        end else begin
            blank_d = 1'b0;
            if (wrap) begin
                cnt_d = '0;
                idx_d = idx_q + 2'd1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end

            // A load on the boundary cycle bypasses pending so it is not delayed a whole frame.
            if (boundary) begin
                if (LOAD) begin
                    act_dig_d  = DIGITS_IN;
                    act_dot_d  = DOTS_IN;
                    pend_vld_d = 1'b0;
                    upd_d      = 1'b1;
                end else if (pend_vld_q) begin
                    act_dig_d  = pend_dig_q;
                    act_dot_d  = pend_dot_q;
                    pend_vld_d = 1'b0;
                    upd_d      = 1'b1;
                end
            end else if (LOAD) begin
                pend_dig_d = DIGITS_IN;
                pend_dot_d = DOTS_IN;
                pend_vld_d = 1'b1;
            end
        end

        seg_d = idx_d;
        bin_d = act_dig_d[{idx_d, 2'b00} +: 4];
        dot_d = act_dot_d[idx_d];
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q      <= '0;
            idx_q      <= 2'd0;
            act_dig_q  <= 16'h0000;
            act_dot_q  <= 4'b1111;
            pend_dig_q <= 16'h0000;
            pend_dot_q <= 4'b0000;
            pend_vld_q <= 1'b0;
            seg_q      <= 2'b00;
            bin_q      <= 4'h0;
            dot_q      <= 1'b1;
            blank_q    <= 1'b1;
            upd_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            act_dig_q  <= act_dig_d;
            act_dot_q  <= act_dot_d;
            pend_dig_q <= pend_dig_d;
            pend_dot_q <= pend_dot_d;
            pend_vld_q <= pend_vld_d;
            seg_q      <= seg_d;
            bin_q      <= bin_d;
            dot_q      <= dot_d;
            blank_q    <= blank_d;
            upd_q      <= upd_d;
        end
    end

    assign SEGMENT    = seg_q;
    assign BINARY_OUT = bin_q;
    assign DOT_OUT    = dot_q;
    assign BLANK      = blank_q;
    assign UPDATED    = upd_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Scoreboard bench: driver pushes reference-model outputs per cycle, monitor pops and compares after each edge.
module tb_display_scan_controller;

    localparam int P     = 4;
    localparam int FRAME = 4 * P;

    typedef struct packed {
        logic [1:0] seg;
        logic [3:0] bin;
        logic       dot;
        logic       blank;
        logic       upd;
    } out_t;

    logic        CLK;
    logic        RESET;
    logic        ENABLE;
    logic        LOAD;
    logic [15:0] DIGITS_IN;
    logic [3:0]  DOTS_IN;
    logic [1:0]  SEGMENT;
    logic [3:0]  BINARY_OUT;
    logic        DOT_OUT;
    logic        BLANK;
    logic        UPDATED;

    display_scan_controller #(.STROBE_PERIOD(P)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .ENABLE     (ENABLE),
        .LOAD       (LOAD),
        .DIGITS_IN  (DIGITS_IN),
        .DOTS_IN    (DOTS_IN),
        .SEGMENT    (SEGMENT),
        .BINARY_OUT (BINARY_OUT),
        .DOT_OUT    (DOT_OUT),
        .BLANK      (BLANK),
        .UPDATED    (UPDATED)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    out_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cycle_no    = 0;

    // Reference model: k counts enabled edges since the scan (re)started.
    int          k;
    logic [15:0] m_act;
    logic [3:0]  m_actdot;
    logic [15:0] m_pend;
    logic [3:0]  m_penddot;
    bit          m_pv;

    task automatic model_step(input bit rst, input bit en, input bit ld,
                              input logic [15:0] d, input logic [3:0] dt,
                              output out_t e);
        int s;
        bit upd;
        upd = 1'b0;
        if (rst) begin
            k = 0; m_act = 16'h0; m_actdot = 4'hf; m_pend = 16'h0; m_penddot = 4'h0; m_pv = 1'b0;
            e = '{2'd0, 4'd0, 1'b1, 1'b1, 1'b0};
        end else if (!en) begin
            k = 0;
            if (ld) begin
                m_act = d; m_actdot = dt; m_pv = 1'b0; upd = 1'b1;
            end
            e = '{2'd0, 4'(m_act & 16'hf), m_actdot[0], 1'b1, upd};
        end else begin
            k++;
            if (k % FRAME == 0) begin
                if (ld) begin
                    m_act = d; m_actdot = dt; m_pv = 1'b0; upd = 1'b1;
                end else if (m_pv) begin
                    m_act = m_pend; m_actdot = m_penddot; m_pv = 1'b0; upd = 1'b1;
                end
            end else if (ld) begin
                m_pend = d; m_penddot = dt; m_pv = 1'b1;
            end
            s = (k / P) % 4;
            e = '{2'(s), 4'((m_act >> (4 * s)) & 16'hf), m_actdot[s], 1'b0, upd};
        end
    endtask

    task automatic cyc(input bit rst, input bit en, input bit ld,
                       input logic [15:0] d, input logic [3:0] dt);
        out_t e;
        @(negedge CLK);
        RESET = rst; ENABLE = en; LOAD = ld; DIGITS_IN = d; DOTS_IN = dt;
        model_step(rst, en, ld, d, dt, e);
        exp_q.push_back(e);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
    endtask

    // Advance so that the next issued cycle lands on a frame boundary.
    task automatic to_boundary();
        for (int i = 0; i < FRAME && ((k + 1) % FRAME) != 0; i++) cyc(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
    endtask

    initial begin : monitor
        out_t e;
        out_t got;
        forever begin
            @(posedge CLK);
            #1;
            cycle_no++;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {SEGMENT, BINARY_OUT, DOT_OUT, BLANK, UPDATED};
                vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL outputs cycle %0d: got seg=%0d bin=%h dot=%b blank=%b upd=%b, want seg=%0d bin=%h dot=%b blank=%b upd=%b",
                             cycle_no, got.seg, got.bin, got.dot, got.blank, got.upd,
                             e.seg, e.bin, e.dot, e.blank, e.upd);
                end
            end
        end
    end

    initial begin : driver
        RESET = 1'b1; ENABLE = 1'b0; LOAD = 1'b0; DIGITS_IN = 16'h0; DOTS_IN = 4'h0;
        k = 0; m_act = 16'h0; m_actdot = 4'hf; m_pend = 16'h0; m_penddot = 4'h0; m_pv = 1'b0;

        // Reset, including a load that must be discarded
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
        cyc(1'b1, 1'b1, 1'b1, 16'h9999, 4'h0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);

        // Plain scan of reset data
        run(2 * FRAME + 4);

        // Load while disabled, then scan
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
        cyc(1'b0, 1'b0, 1'b1, 16'h4321, 4'b1110);
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
        run(FRAME + 2);

        // Load mid-frame while digit 1 is shown
        to_boundary();
        run(P + 1);
        cyc(1'b0, 1'b1, 1'b1, 16'hBEEF, 4'b0101);
        run(2 * FRAME);

        // Two loads in one frame, last one wins
        to_boundary();
        run(3);
        cyc(1'b0, 1'b1, 1'b1, 16'h1111, 4'b0011);
        run(2);
        cyc(1'b0, 1'b1, 1'b1, 16'h2222, 4'b1100);
        run(2 * FRAME);

        // Load exactly on the boundary cycle
        to_boundary();
        cyc(1'b0, 1'b1, 1'b1, 16'hAAAA, 4'b1010);
        run(2 * FRAME + 1);

        // Reset mid-frame with pending data
        to_boundary();
        run(5);
        cyc(1'b0, 1'b1, 1'b1, 16'h5555, 4'b0000);
        run(2);
        cyc(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
        run(2 * FRAME + 2);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
                ($urandom_range(0, 5) == 0),
                16'($urandom_range(0, 65535)), 4'($urandom_range(0, 15)));
        end

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge CLK);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors never checked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
